rtc_bcd_clock: RTL

Parametrised time-of-day clock for the board seven-segment display path. It divides the system clock to a 1 Hz tick and keeps seconds, minutes and hours in BCD with correct 24-hour wrap. Outputs are 24-hour or 12-hour with a PM flag, selected at runtime. Debounced, edge-detected buttons set hours and minutes, and a clear button zeroes the seconds; the digit outputs drive the display mux directly.

---
 rtl/rtc_bcd_clock.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/rtc_bcd_clock.sv
// BCD time-of-day clock: 1 Hz prescaler, HH:MM:SS counters, debounced set buttons
// and a registered 24/12-hour display conversion for the seven-segment mux.
module rtc_bcd_clock #(
    parameter int unsigned CLK_HZ          = 100_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       btn_hr,
    input  logic       btn_min,
    input  logic       btn_clr,
    input  logic       fmt12,
    output logic       tick_1hz,
    output logic [5:0] sec_led,
    output logic [3:0] S_1,
    output logic [3:0] S_0,
    output logic [3:0] M_1,
    output logic [3:0] M_0,
    output logic [3:0] H_1,
    output logic [3:0] H_0,
    output logic       pm
);

    localparam int unsigned PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned NBTN  = 3;
    localparam int unsigned B_HR  = 0;
    localparam int unsigned B_MIN = 1;
    localparam int unsigned B_CLR = 2;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    // Advance a two-digit BCD value, wrapping to 00 after 'last'.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
        logic [7:0] r;
        if (v == last) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    logic [NBTN-1:0]           btn_raw;
    logic [NBTN-1:0]           sync1_q, sync1_d;
    logic [NBTN-1:0]           sync2_q, sync2_d;
    logic [NBTN-1:0]           deb_q, deb_d;
    logic [NBTN-1:0][DB_W-1:0] cnt_q, cnt_d;
    logic [NBTN-1:0]           press_c;

    logic [PRE_W-1:0] presc_q, presc_d;
    logic             tick_q, tick_d;
    logic             tick_c;
    logic             sec_carry_c, min_carry_c;
    logic [7:0]       sec_q, sec_d;
    logic [7:0]       min_q, min_d;
    logic [7:0]       hr_q, hr_d;

    logic [5:0] sec_led_q, sec_led_d;
    logic [7:0] s_disp_q, s_disp_d;
    logic [7:0] m_disp_q, m_disp_d;
    logic [7:0] h_disp_q, h_disp_d;
    logic       pm_q, pm_d;
    logic [4:0] hr_bin_c;
    logic [4:0] h12_c;

    assign btn_raw = {btn_clr, btn_min, btn_hr};

    // Synchronise, then accept a level only after DEBOUNCE_CYCLES differing samples.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = '0;
        press_c = '0;
        for (int i = 0; i < int'(NBTN); i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    deb_d[i]   = sync2_q[i];
                    press_c[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Timekeeping; a set press on a field overrides any carry arriving at it.
    always_comb begin
        tick_c      = (presc_q == PRE_LAST);
        presc_d     = tick_c ? '0 : presc_q + PRE_W'(1);
        tick_d      = tick_c;
        sec_d       = sec_q;
        min_d       = min_q;
        hr_d        = hr_q;
        sec_carry_c = 1'b0;
        min_carry_c = 1'b0;

        if (press_c[B_CLR]) begin
            presc_d = '0;
            tick_d  = 1'b0;
            sec_d   = 8'h00;
        end else if (tick_c) begin
            sec_d       = bcd_inc(sec_q, 8'h59);
            sec_carry_c = (sec_q == 8'h59);
        end

        if (press_c[B_MIN]) begin
            min_d = bcd_inc(min_q, 8'h59);
        end else if (sec_carry_c) begin
            min_d       = bcd_inc(min_q, 8'h59);
            min_carry_c = (min_q == 8'h59);
        end

        if (press_c[B_HR] || min_carry_c) begin
            hr_d = bcd_inc(hr_q, 8'h23);
        end
    end

    // Display conversion from the current internal time.
    always_comb begin
        hr_bin_c  = 5'(hr_q[7:4]) * 5'd10 + 5'(hr_q[3:0]);
        sec_led_d = 6'(sec_q[7:4]) * 6'd10 + 6'(sec_q[3:0]);
        s_disp_d  = sec_q;
        m_disp_d  = min_q;
        h_disp_d  = hr_q;
        pm_d      = 1'b0;
        if (hr_bin_c == 5'd0) begin
            h12_c = 5'd12;
        end else if (hr_bin_c > 5'd12) begin
            h12_c = hr_bin_c - 5'd12;
        end else begin
            h12_c = hr_bin_c;
        end
        if (fmt12) begin
            h_disp_d = (h12_c >= 5'd10) ? {4'd1, 4'(h12_c - 5'd10)} : {4'd0, 4'(h12_c)};
            pm_d     = (hr_bin_c >= 5'd12);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            cnt_q     <= '0;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            sec_q     <= 8'h00;
            min_q     <= 8'h00;
            hr_q      <= 8'h00;
            sec_led_q <= '0;
            s_disp_q  <= 8'h00;
            m_disp_q  <= 8'h00;
            h_disp_q  <= 8'h00;
            pm_q      <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            cnt_q     <= cnt_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            hr_q      <= hr_d;
            sec_led_q <= sec_led_d;
            s_disp_q  <= s_disp_d;
            m_disp_q  <= m_disp_d;
            h_disp_q  <= h_disp_d;
            pm_q      <= pm_d;
        end
    end

    assign tick_1hz = tick_q;
    assign sec_led  = sec_led_q;
    assign S_1      = s_disp_q[7:4];
    assign S_0      = s_disp_q[3:0];
    assign M_1      = m_disp_q[7:4];
    assign M_0      = m_disp_q[3:0];
    assign H_1      = h_disp_q[7:4];
    assign H_0      = h_disp_q[3:0];
    assign pm       = pm_q;

endmodule
